input_mapper: RTL and testbench
===============================

// Module: input_mapper
// PURPOSE
//  Decodes MiSTer ps2_key events and per-player joystick words into registered arcade
//  control outputs for up to 4 players. Adds E0-aware key decode, SOCD cleaning,
//  per-button autofire, coin-pulse stretching and latched pause.
//  Sits between hps_io and the core; replaces the ad-hoc key/joystick OR logic in emu.
// PARAMETERS
//  NUM_PLAYERS        2       players, 1..4; keyboard map covers P1/P2 only
//  NUM_BUTTONS        3       fire buttons per player, 1..8
//  SOCD_MODE          1       0 = pass-through, 1 = opposing directions both -> neutral
//  AUTOFIRE_DIV       800000  clk_sys cycles per autofire half-period, >= 2
//  COIN_PULSE_CYCLES  4000000 coin output high time in cycles, >= 1
//  JW (localparam)    NUM_BUTTONS+7  joystick word width per player
// PORTS
//  clk_sys        in   1              system clock
//  reset_n        in   1              async active-low reset
//  ps2_key        in   11             [10] toggle, [9] pressed, [8] extended, [7:0] code
//  joystick       in   NUM_PLAYERS*JW per player: [0]R [1]L [2]D [3]U [4+i]btn i,
//                                     [4+NB]start [5+NB]coin [6+NB]pause
//  autofire_mask  in   NUM_PLAYERS*NUM_BUTTONS  1 = autofire on that button
//  p_dir          out  NUM_PLAYERS*4  per player {up,down,left,right}
//  p_buttons      out  NUM_PLAYERS*NUM_BUTTONS
//  p_start        out  NUM_PLAYERS
//  p_coin         out  NUM_PLAYERS    stretched coin pulse
//  p_pause        out  NUM_PLAYERS    latched pause state
//  service        out  2              {key 0, key 9}
// BEHAVIOUR
//  Reset (reset_n low, any time): all key regs, outputs, latches, counters -> 0;
//   autofire phase -> 1; primed -> 0. Takes effect immediately (async).
//  Event detect: old_toggle <= ps2_key[10] every cycle. First cycle after reset only
//   sets primed=1 (no decode). Event = primed && ps2_key[10] != old_toggle.
//  Key decode (on event, key reg <= pressed, visible 1 cycle later):
//   extended=1 required: 75 up, 72 down, 6B left, 74 right (P1).
//   extended ignored: 14 ctrl/11 alt/29 space = P1 btn0/1/2; 16 P1 start; 2E P1 coin;
//   4D P1 pause; 2D/2B/23/34 = P2 up/down/left/right; 1C/1B/15 P2 btn0/1/2;
//   1E P2 start; 36 P2 coin; 46 service[0]; 45 service[1]. Unlisted codes ignored.
//   Keys for buttons >= 3 or players >= 2 do not exist (tie to 0).
//  raw = key | joystick bit (combinational). Outputs registered from raw:
//   joystick -> output 1 cycle; ps2 event -> output 2 cycles.
//  SOCD_MODE=1: up&down raw both 1 -> both 0; left&right likewise; independent axes.
//  Autofire: one shared counter 0..AUTOFIRE_DIV-1; at wrap phase toggles.
//   button_out = raw & (mask ? phase : 1). Mask change takes effect next cycle.
//  Coin: rising edge of raw coin while ccnt==0 loads ccnt=COIN_PULSE_CYCLES;
//   ccnt decrements to 0; p_coin = (ccnt!=0). Edges while ccnt!=0 dropped; hold length
//   irrelevant; new edge needed after expiry.
//  Pause: rising edge of raw pause toggles latch; p_pause = latch. Holding = one toggle.
//  Edge detect regs per channel reset to 0 -> input high across reset release counts
//   as an edge on first clock.
//  Simultaneous key and joystick on same control: OR, no priority.
// STRUCTURE
//  input_pkg: scan-code localparams, joystick bit index constants (JOY_R..JOY_PAUSE
//   as functions of NUM_BUTTONS), SOCD mode enum.
//  input_mapper: ps2 event detect, key decode, autofire divider, raw OR.
//  input_channel: per-player SOCD, autofire gate, coin stretcher, pause latch,
//   output regs; generate-instantiated NUM_PLAYERS times.
// TESTING
//  T1 ps2 {toggle flip, pressed=1, ext=1, 75} -> p_dir P1 up=1 at +2 cycles; same
//     without ext -> no change; release event -> up=0.
//  T2 toggle=1 held through reset release -> no key change; primed set, next flip decodes.
//  T3 SOCD_MODE=1, P1 joystick U+D+R -> dir {0,0,0,1}; SOCD_MODE=0 -> {1,1,0,1}.
//  T4 AUTOFIRE_DIV=4, mask bit0=1, btn0 held -> output 1,1,1,1,0,0,0,0 repeating;
//     mask=0 -> steady 1.
//  T5 COIN_PULSE_CYCLES=10, coin held 50 cycles -> p_coin high exactly 10; second edge
//     at cycle 5 dropped; edge at cycle 12 -> new 10-cycle pulse.
//  T6 pause pressed twice -> p_pause 1 then 0; reset_n pulsed mid-pulse -> all outputs 0.

Source files
------------

// File: rtl/input_pkg.sv
// Shared constants for the arcade input mapper: PS/2 scan codes, joystick word
// bit positions and the SOCD cleaning mode.
package input_pkg;

   // Keys whose scan code is only valid with the E0 prefix
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   localparam logic [7:0] SC_CTRL  = 8'h14;
   localparam logic [7:0] SC_ALT   = 8'h11;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_1     = 8'h16;
   localparam logic [7:0] SC_5     = 8'h2E;
   localparam logic [7:0] SC_P     = 8'h4D;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_F     = 8'h2B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_G     = 8'h34;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_Q     = 8'h15;
   localparam logic [7:0] SC_2     = 8'h1E;
   localparam logic [7:0] SC_6     = 8'h36;
   localparam logic [7:0] SC_9     = 8'h46;
   localparam logic [7:0] SC_0     = 8'h45;

   localparam int KEY_PLAYERS = 2;
   localparam int KEY_BUTTONS = 3;

   localparam int JOY_R = 0;
   localparam int JOY_L = 1;
   localparam int JOY_D = 2;
   localparam int JOY_U = 3;

   function automatic int joy_btn(input int i);
      return 4 + i;
   endfunction

   function automatic int joy_start(input int nb);
      return 4 + nb;
   endfunction

   function automatic int joy_coin(input int nb);
      return 5 + nb;
   endfunction

   function automatic int joy_pause(input int nb);
      return 6 + nb;
   endfunction

   function automatic int joy_width(input int nb);
      return nb + 7;
   endfunction

   typedef enum logic {
      SOCD_PASS    = 1'b0,
      SOCD_NEUTRAL = 1'b1
   } socd_mode_e;

   typedef struct packed {
      logic                   up;
      logic                   down;
      logic                   left;
      logic                   right;
      logic [KEY_BUTTONS-1:0] btn;
      logic                   start;
      logic                   coin;
      logic                   pause;
   } key_state_t;

endpackage

// File: rtl/input_channel.sv
// One player's output stage: SOCD cleaning, autofire gating, coin pulse
// stretching and pause latch, all registered from the merged raw word.
module input_channel
   import input_pkg::*;
#(
   parameter int  NUM_BUTTONS       = 3,
   parameter int  SOCD_MODE         = 1,
   parameter int  COIN_PULSE_CYCLES = 4000000,
   localparam int JW                = joy_width(NUM_BUTTONS)
)(
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [JW-1:0]          raw,
   input  logic [NUM_BUTTONS-1:0] autofire_mask,
   input  logic                   af_phase,
   output logic [3:0]             dir,
   output logic [NUM_BUTTONS-1:0] buttons,
   output logic                   start,
   output logic                   coin,
   output logic                   pause
);

   localparam socd_mode_e MODE   = (SOCD_MODE != 0) ? SOCD_NEUTRAL : SOCD_PASS;
   localparam int         CW     = $clog2(COIN_PULSE_CYCLES + 1);
   localparam int         JOY_B0 = joy_btn(0);
   localparam int         JOY_ST = joy_start(NUM_BUTTONS);
   localparam int         JOY_CN = joy_coin(NUM_BUTTONS);
   localparam int         JOY_PS = joy_pause(NUM_BUTTONS);

   logic                   up, down, left, right;
   logic [NUM_BUTTONS-1:0] btn_gated;
   logic                   coin_prev, pause_prev, pause_q;
   logic                   coin_rise, pause_rise;
   logic [CW-1:0]          coin_cnt;

   // Opposing directions cancel per axis; the two axes never affect each other
   always_comb begin
      up    = raw[JOY_U];
      down  = raw[JOY_D];
      left  = raw[JOY_L];
      right = raw[JOY_R];
      if (MODE == SOCD_NEUTRAL) begin
         if (up && down) begin
            up   = 1'b0;
            down = 1'b0;
         end
         if (left && right) begin
            left  = 1'b0;
            right = 1'b0;
         end
      end
   end

   assign btn_gated  = raw[JOY_B0 +: NUM_BUTTONS] & (~autofire_mask | {NUM_BUTTONS{af_phase}});
   assign coin_rise  = raw[JOY_CN] & ~coin_prev;
   assign pause_rise = raw[JOY_PS] & ~pause_prev;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dir        <= '0;
         buttons    <= '0;
         start      <= 1'b0;
         coin_prev  <= 1'b0;
         pause_prev <= 1'b0;
         pause_q    <= 1'b0;
         coin_cnt   <= '0;
      end else begin
         dir        <= {up, down, left, right};
         buttons    <= btn_gated;
         start      <= raw[JOY_ST];
         coin_prev  <= raw[JOY_CN];
         pause_prev <= raw[JOY_PS];
         if (pause_rise) pause_q <= ~pause_q;
         // Edges arriving during a pulse are dropped rather than queued
         if (coin_cnt != '0)  coin_cnt <= coin_cnt - CW'(1);
         else if (coin_rise)  coin_cnt <= CW'(COIN_PULSE_CYCLES);
      end
   end

   assign coin  = (coin_cnt != '0);
   assign pause = pause_q;

endmodule

// File: rtl/input_mapper.sv
// Arcade input mapper: decodes ps2_key events, ORs them with joystick words and
// drives per-player channels sharing one autofire divider.
module input_mapper
   import input_pkg::*;
#(
   parameter int  NUM_PLAYERS       = 2,
   parameter int  NUM_BUTTONS       = 3,
   parameter int  SOCD_MODE         = 1,
   parameter int  AUTOFIRE_DIV      = 800000,
   parameter int  COIN_PULSE_CYCLES = 4000000,
   localparam int JW                = joy_width(NUM_BUTTONS)
)(
   input  logic                               clk_sys,
   input  logic                               reset_n,
   input  logic [10:0]                        ps2_key,
   input  logic [NUM_PLAYERS*JW-1:0]          joystick,
   input  logic [NUM_PLAYERS*NUM_BUTTONS-1:0] autofire_mask,
   output logic [NUM_PLAYERS*4-1:0]           p_dir,
   output logic [NUM_PLAYERS*NUM_BUTTONS-1:0] p_buttons,
   output logic [NUM_PLAYERS-1:0]             p_start,
   output logic [NUM_PLAYERS-1:0]             p_coin,
   output logic [NUM_PLAYERS-1:0]             p_pause,
   output logic [1:0]                         service
);

   localparam int AFW = $clog2(AUTOFIRE_DIV);
   localparam int KB  = (NUM_BUTTONS < KEY_BUTTONS) ? NUM_BUTTONS : KEY_BUTTONS;

   logic                              old_toggle, primed, ps2_event;
   logic                              ps2_pressed, ps2_ext;
   logic [7:0]                        ps2_code;
   key_state_t [KEY_PLAYERS-1:0]      key_q, key_d;
   logic [1:0]                        service_q, service_d;
   logic [AFW-1:0]                    af_cnt;
   logic                              af_phase;

   assign ps2_pressed = ps2_key[9];
   assign ps2_ext     = ps2_key[8];
   assign ps2_code    = ps2_key[7:0];
   // primed masks the first cycle so a toggle already high at reset release is not an event
   assign ps2_event   = primed && (ps2_key[10] != old_toggle);

   always_comb begin
      // NOTE: defaults first so every path assigns key_d/service_d and no latch is inferred.
      key_d     = key_q;
      service_d = service_q;
      if (ps2_event) begin
         case (ps2_code)
            SC_UP:    if (ps2_ext) key_d[0].up    = ps2_pressed;
            SC_DOWN:  if (ps2_ext) key_d[0].down  = ps2_pressed;
            SC_LEFT:  if (ps2_ext) key_d[0].left  = ps2_pressed;
            SC_RIGHT: if (ps2_ext) key_d[0].right = ps2_pressed;
            SC_CTRL:  key_d[0].btn[0] = ps2_pressed;
            SC_ALT:   key_d[0].btn[1] = ps2_pressed;
            SC_SPACE: key_d[0].btn[2] = ps2_pressed;
            SC_1:     key_d[0].start  = ps2_pressed;
            SC_5:     key_d[0].coin   = ps2_pressed;
            SC_P:     key_d[0].pause  = ps2_pressed;
            SC_R:     key_d[1].up     = ps2_pressed;
            SC_F:     key_d[1].down   = ps2_pressed;
            SC_D:     key_d[1].left   = ps2_pressed;
            SC_G:     key_d[1].right  = ps2_pressed;
            SC_A:     key_d[1].btn[0] = ps2_pressed;
            SC_S:     key_d[1].btn[1] = ps2_pressed;
            SC_Q:     key_d[1].btn[2] = ps2_pressed;
            SC_2:     key_d[1].start  = ps2_pressed;
            SC_6:     key_d[1].coin   = ps2_pressed;
            SC_9:     service_d[0]    = ps2_pressed;
            SC_0:     service_d[1]    = ps2_pressed;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         old_toggle <= 1'b0;
         primed     <= 1'b0;
         key_q      <= '0;
         service_q  <= '0;
         service    <= '0;
      end else begin
         old_toggle <= ps2_key[10];
         primed     <= 1'b1;
         key_q      <= key_d;
         service_q  <= service_d;
         service    <= service_q;
      end
   end

   // Shared autofire divider; phase starts high so a freshly pressed button fires at once
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt   <= '0;
         af_phase <= 1'b1;
      end else if (af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
         af_cnt   <= '0;
         af_phase <= ~af_phase;
      end else begin
         af_cnt   <= af_cnt + AFW'(1);
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [JW-1:0] key_word;
      logic [JW-1:0] raw;

      if (p < KEY_PLAYERS) begin : g_keys
         always_comb begin
            key_word                         = '0;
            key_word[JOY_U]                  = key_q[p].up;
            key_word[JOY_D]                  = key_q[p].down;
            key_word[JOY_L]                  = key_q[p].left;
            key_word[JOY_R]                  = key_q[p].right;
            for (int b = 0; b < KB; b++)
               key_word[joy_btn(b)]          = key_q[p].btn[b];
            key_word[joy_start(NUM_BUTTONS)] = key_q[p].start;
            key_word[joy_coin(NUM_BUTTONS)]  = key_q[p].coin;
            key_word[joy_pause(NUM_BUTTONS)] = key_q[p].pause;
         end
      end else begin : g_no_keys
         assign key_word = '0;
      end

      assign raw = key_word | joystick[p*JW +: JW];

      input_channel #(
         .NUM_BUTTONS       (NUM_BUTTONS),
         .SOCD_MODE         (SOCD_MODE),
         .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES)
      ) u_channel (
         .clk_sys       (clk_sys),
         .reset_n       (reset_n),
         .raw           (raw),
         .autofire_mask (autofire_mask[p*NUM_BUTTONS +: NUM_BUTTONS]),
         .af_phase      (af_phase),
         .dir           (p_dir[p*4 +: 4]),
         .buttons       (p_buttons[p*NUM_BUTTONS +: NUM_BUTTONS]),
         .start         (p_start[p]),
         .coin          (p_coin[p]),
         .pause         (p_pause[p])
      );
   end

endmodule

// File: tb/tb_input_mapper.sv
// Directed bench for input_mapper: two instances differing only in SOCD mode,
// short autofire divider and coin pulse so every behaviour fits in a few hundred cycles.
module tb_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [10:0] ps2_key;
   logic [19:0] joystick;
   logic [5:0]  autofire_mask;

   logic [7:0]  p_dir,     q_dir;
   logic [5:0]  p_buttons, q_buttons;
   logic [1:0]  p_start,   q_start;
   logic [1:0]  p_coin,    q_coin;
   logic [1:0]  p_pause,   q_pause;
   logic [1:0]  service,   q_service;

   int checks = 0;
   int errors = 0;
   int cyc;
   int n;
   logic [7:0] pattern;

   always #5 clk_sys = ~clk_sys;

   // Edges seen since the last reset release, used to align to the autofire phase
   always @(posedge clk_sys or negedge reset_n)
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;

   input_mapper #(
      .NUM_PLAYERS(2), .NUM_BUTTONS(3), .SOCD_MODE(1),
      .AUTOFIRE_DIV(4), .COIN_PULSE_CYCLES(10)
   ) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
      .joystick(joystick), .autofire_mask(autofire_mask),
      .p_dir(p_dir), .p_buttons(p_buttons), .p_start(p_start),
      .p_coin(p_coin), .p_pause(p_pause), .service(service)
   );

   input_mapper #(
      .NUM_PLAYERS(2), .NUM_BUTTONS(3), .SOCD_MODE(0),
      .AUTOFIRE_DIV(4), .COIN_PULSE_CYCLES(10)
   ) dut_pass (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
      .joystick(joystick), .autofire_mask(autofire_mask),
      .p_dir(q_dir), .p_buttons(q_buttons), .p_start(q_start),
      .p_coin(q_coin), .p_pause(q_pause), .service(q_service)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step(input int cycles);
      repeat (cycles) begin
         @(posedge clk_sys);
         #1;
      end
   endtask

   task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pressed, ext, code};
   endtask

   initial begin
      reset_n       = 1'b0;
      ps2_key       = 11'h400;
      joystick      = '0;
      autofire_mask = '0;

      // Reset state
      #12;
      check("rst_dir",     p_dir,     8'h00);
      check("rst_buttons", p_buttons, 6'h00);
      check("rst_start",   p_start,   2'b00);
      check("rst_coin",    p_coin,    2'b00);
      check("rst_pause",   p_pause,   2'b00);
      check("rst_service", service,   2'b00);

      // T2: toggle high across reset release is not an event
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      step(3);
      check("prime_no_event", {p_dir, p_buttons, p_start, service}, 18'h0);

      // T1: extended up arrow, two-cycle latency
      send(1'b1, 1'b1, 8'h75);
      step(1);
      check("up_lat1", p_dir, 8'h00);
      step(1);
      check("up_lat2", p_dir, 8'h08);
      send(1'b0, 1'b1, 8'h75);
      step(2);
      check("up_release", p_dir, 8'h00);
      send(1'b1, 1'b0, 8'h75);
      step(2);
      check("up_no_ext", p_dir, 8'h00);

      // Other key mappings, extended flag ignored where allowed
      send(1'b1, 1'b0, 8'h29);
      step(2);
      check("space_p1_btn2", p_buttons, 6'b000100);
      send(1'b0, 1'b0, 8'h29);
      step(2);
      send(1'b1, 1'b0, 8'h1E);
      step(2);
      check("p2_start_key", p_start, 2'b10);
      send(1'b0, 1'b0, 8'h1E);
      step(2);
      send(1'b1, 1'b1, 8'h46);
      step(2);
      check("service0_ext", service, 2'b01);
      send(1'b0, 1'b0, 8'h46);
      step(2);
      send(1'b1, 1'b0, 8'h23);
      step(2);
      check("p2_left_key", p_dir, 8'h20);
      send(1'b0, 1'b0, 8'h23);
      step(2);
      send(1'b1, 1'b0, 8'h5A);
      step(2);
      check("unlisted_code", {p_dir, p_buttons, p_start, p_coin, p_pause, service}, 22'h0);

      // T3: SOCD cleaning vs pass-through, one-cycle joystick latency
      joystick = 20'h0000D;
      step(1);
      check("socd_udr",      p_dir[3:0], 4'b0001);
      check("pass_udr",      q_dir[3:0], 4'b1101);
      joystick = 20'h0000B;
      step(1);
      check("socd_ulr",      p_dir[3:0], 4'b1000);
      check("pass_ulr",      q_dir[3:0], 4'b1011);
      joystick = {10'h003, 10'h008};
      step(1);
      check("socd_players",  p_dir, 8'h08);
      check("pass_players",  q_dir, 8'h38);
      joystick = 20'h00008;
      send(1'b1, 1'b1, 8'h72);
      step(2);
      check("socd_key_or_joy", p_dir[3:0], 4'b0000);
      check("pass_key_or_joy", q_dir[3:0], 4'b1100);
      send(1'b0, 1'b1, 8'h72);
      joystick = '0;
      step(2);

      // T4: autofire on P1 btn0 with a 4-cycle half period
      joystick      = 20'h00010;
      autofire_mask = 6'b000001;
      step(1);
      for (int i = 0; i < 8 && (cyc % 8) != 0; i++) step(1);
      pattern = 8'b00001111;
      for (int i = 0; i < 8; i++) begin
         step(1);
         check($sformatf("af_on_%0d", i), p_buttons[0], pattern[i]);
      end
      autofire_mask = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check($sformatf("af_off_%0d", i), p_buttons[0], 1'b1);
      end
      joystick = '0;
      step(2);

      // T5: coin held for 50 cycles gives exactly one 10-cycle pulse
      joystick[8] = 1'b1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (p_coin[0]) n++;
      end
      check("coin_hold_len", n, 10);
      joystick[8] = 1'b0;
      step(2);
      joystick[8] = 1'b1;
      step(1);
      check("coin_edge1", p_coin[0], 1'b1);
      joystick[8] = 1'b0;
      step(3);
      joystick[8] = 1'b1;
      step(1);
      joystick[8] = 1'b0;
      step(5);
      check("coin_s10", p_coin[0], 1'b1);
      step(1);
      check("coin_s11_dropped", p_coin[0], 1'b0);
      joystick[8] = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (p_coin[0]) n++;
      end
      check("coin_second_len", n, 10);
      joystick[8] = 1'b0;
      step(2);

      // T6: pause latch from keyboard and a held joystick pause
      send(1'b1, 1'b0, 8'h4D);
      step(2);
      check("pause_press1", p_pause, 2'b01);
      send(1'b0, 1'b0, 8'h4D);
      step(2);
      check("pause_release1", p_pause, 2'b01);
      send(1'b1, 1'b0, 8'h4D);
      step(2);
      check("pause_press2", p_pause, 2'b00);
      send(1'b0, 1'b0, 8'h4D);
      step(2);
      joystick[19] = 1'b1;
      step(5);
      check("pause_p2_hold", p_pause, 2'b10);
      joystick[19] = 1'b0;

      // Asynchronous reset in the middle of a coin pulse
      joystick[4] = 1'b1;
      joystick[8] = 1'b1;
      step(3);
      check("pre_rst_coin", p_coin, 2'b01);
      reset_n = 1'b0;
      #1;
      check("mid_rst_dir",     p_dir,     8'h00);
      check("mid_rst_buttons", p_buttons, 6'h00);
      check("mid_rst_start",   p_start,   2'b00);
      check("mid_rst_coin",    p_coin,    2'b00);
      check("mid_rst_pause",   p_pause,   2'b00);
      check("mid_rst_service", service,   2'b00);
      step(1);
      reset_n = 1'b1;
      step(1);
      check("rel_coin_edge", p_coin,    2'b01);
      check("rel_button",    p_buttons, 6'b000001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
